// File: rtl/ftdi_tx_arbiter_pkg.sv
// Shared types and helpers for the FTDI TX arbiter: FSM state encoding,
// default header tag and a constant ceil-log2 used for register sizing.
package ftdi_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_REQ  = 2'd2,
      S_ACK  = 2'd3
   } state_t;

   localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/ftdi_tx_arbiter_if.sv
// Requester and FTDI-side signals of the TX arbiter. The slave modport is the
// arbiter's view; the master modport is the view of the surrounding clients.
interface ftdi_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   in_req_valid;
   logic [8*NUM_REQ-1:0] in_req_data;
   logic [NUM_REQ-1:0]   in_req_last;
   logic [NUM_REQ-1:0]   out_req_ready;
   logic [7:0]           out_ctrl_data;
   logic                 out_ctrl_tx_rdy;
   logic                 in_ctrl_tx_ack;
   logic [NUM_REQ-1:0]   out_grant;
   logic                 out_busy;
   logic                 out_timeout;

   modport slave (
      input  in_req_valid, in_req_data, in_req_last, in_ctrl_tx_ack,
      output out_req_ready, out_ctrl_data, out_ctrl_tx_rdy, out_grant, out_busy, out_timeout
   );

   modport master (
      output in_req_valid, in_req_data, in_req_last, in_ctrl_tx_ack,
      input  out_req_ready, out_ctrl_data, out_ctrl_tx_rdy, out_grant, out_busy, out_timeout
   );
endinterface

// File: rtl/ftdi_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: one-hot grant of the first request at or
// after the pointer, wrapping. Rotate right, isolate lowest bit, rotate back.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant
);
   logic [2*NUM_REQ-1:0] w_dbl_req;
   logic [NUM_REQ-1:0]   w_rot_req;
   logic [NUM_REQ-1:0]   w_rot_pick;
   logic [2*NUM_REQ-1:0] w_dbl_grant;

   assign w_dbl_req   = {i_req, i_req} >> i_ptr;
   assign w_rot_req   = w_dbl_req[NUM_REQ-1:0];
   assign w_rot_pick  = w_rot_req & (~w_rot_req + NUM_REQ'(1));
   assign w_dbl_grant = {w_rot_pick, w_rot_pick} << i_ptr;
   assign o_grant     = w_dbl_grant[2*NUM_REQ-1:NUM_REQ];
endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one FTDI TX four-phase
// interlock among NUM_REQ byte-stream requesters, with optional header byte.
module ftdi_tx_arbiter
   import ftdi_tx_arbiter_pkg::*;
#(
   parameter int         NUM_REQ      = 4,
   parameter int         HDR_EN       = 1,
   parameter logic [3:0] HDR_TAG      = HDR_TAG_DEFAULT,
   parameter int         IDLE_TIMEOUT = 255
) (
   input  logic               in_clk,
   input  logic               in_reset_n,
   ftdi_tx_arbiter_if.slave   bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
   localparam int CNT_W = clog2(IDLE_TIMEOUT + 1);

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_grant;
   logic [PTR_W-1:0]     r_owner;
   logic [PTR_W-1:0]     r_ptr;
   logic                 r_busy;
   logic [NUM_REQ-1:0]   r_ready;
   logic                 r_tx_rdy;
   logic [7:0]           r_data;
   logic                 r_last;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_timeout;

   logic [NUM_REQ-1:0]   w_pick;
   logic [PTR_W-1:0]     w_pick_idx;
   logic                 w_owner_valid;
   logic [7:0]           w_owner_data;
   logic                 w_owner_last;
   logic [PTR_W-1:0]     w_ptr_next;

   function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] vec);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (vec[k]) begin
            idx = PTR_W'(k);
         end
      end
      return idx;
   endfunction

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .i_req   (bus.in_req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_pick)
   );

   assign w_pick_idx    = onehot_idx(w_pick);
   assign w_owner_valid = bus.in_req_valid[r_owner];
   assign w_owner_last  = bus.in_req_last[r_owner];
   assign w_owner_data  = bus.in_req_data[{r_owner, 3'b000} +: 8];
   assign w_ptr_next    = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

   // Arbitration FSM with data/last holding, stall timeout and RR pointer.
   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         r_state   <= S_IDLE;
         r_grant   <= '0;
         r_owner   <= '0;
         r_ptr     <= '0;
         r_busy    <= 1'b0;
         r_ready   <= '0;
         r_tx_rdy  <= 1'b0;
         r_data    <= 8'h00;
         r_last    <= 1'b0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pick != '0) begin
                  r_grant <= w_pick;
                  r_owner <= w_pick_idx;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  if (HDR_EN != 0) begin
                     r_data   <= {HDR_TAG, 4'(w_pick_idx)};
                     r_last   <= 1'b0;
                     r_tx_rdy <= 1'b1;
                     r_state  <= S_REQ;
                  end else begin
                     r_ready <= w_pick;
                     r_state <= S_WAIT;
                  end
               end
            end
            // A byte arriving on the timeout cycle is still accepted.
            S_WAIT: begin
               if (w_owner_valid) begin
                  r_data   <= w_owner_data;
                  r_last   <= w_owner_last;
                  r_ready  <= '0;
                  r_cnt    <= '0;
                  r_tx_rdy <= 1'b1;
                  r_state  <= S_REQ;
               end else if (r_cnt == CNT_W'(IDLE_TIMEOUT)) begin
                  r_timeout <= 1'b1;
                  r_ready   <= '0;
                  r_grant   <= '0;
                  r_busy    <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_REQ: begin
               if (bus.in_ctrl_tx_ack) begin
                  r_tx_rdy <= 1'b0;
                  r_state  <= S_ACK;
               end
            end
            S_ACK: begin
               if (!bus.in_ctrl_tx_ack) begin
                  if (r_last) begin
                     r_ptr   <= w_ptr_next;
                     r_grant <= '0;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_ready <= r_grant;
                     r_cnt   <= '0;
                     r_state <= S_WAIT;
                  end
               end
            end
            default: begin
               r_grant  <= '0;
               r_busy   <= 1'b0;
               r_ready  <= '0;
               r_tx_rdy <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.out_req_ready   = r_ready;
   assign bus.out_ctrl_data   = r_data;
   assign bus.out_ctrl_tx_rdy = r_tx_rdy;
   assign bus.out_grant       = r_grant;
   assign bus.out_busy        = r_busy;
   assign bus.out_timeout     = r_timeout;
endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Directed bench: two arbiters (with/without header) fed by queue-backed
// requesters and an FTDI ack model with configurable latency and hold time.
module tb_ftdi_tx_arbiter;
   localparam int TMO = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ftdi_tx_arbiter_if #(.NUM_REQ(4)) bus_a ();
   ftdi_tx_arbiter_if #(.NUM_REQ(4)) bus_b ();

   ftdi_tx_arbiter #(.NUM_REQ(4), .HDR_EN(1), .HDR_TAG(4'hA), .IDLE_TIMEOUT(TMO)) dut (
      .in_clk     (clk),
      .in_reset_n (rst_n),
      .bus        (bus_a)
   );

   ftdi_tx_arbiter #(.NUM_REQ(4), .HDR_EN(0), .HDR_TAG(4'hA), .IDLE_TIMEOUT(255)) dut_nh (
      .in_clk     (clk),
      .in_reset_n (rst_n),
      .bus        (bus_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [8:0] sq_a [4][$];
   logic [8:0] sq_b [$];
   logic [7:0] log_a [$];
   logic [7:0] log_b [$];
   logic [3:0] glog_a [$];
   int ack_lat = 2;
   int ack_hold = 0;
   int to_cnt = 0;
   int stall_cnt = 0;
   int viol_cnt = 0;

   // Requesters of arbiter A: present queue head, pop after an accepted byte.
   initial begin
      logic [3:0] acc;
      logic [3:0] v;
      logic [3:0] l;
      logic [31:0] d;
      acc = 4'b0000;
      bus_a.in_req_valid = 4'b0000;
      bus_a.in_req_last  = 4'b0000;
      bus_a.in_req_data  = 32'h0;
      forever begin
         @(negedge clk);
         v = 4'b0000; l = 4'b0000; d = 32'h0;
         for (int i = 0; i < 4; i++) begin
            if (rst_n && acc[i] && sq_a[i].size() > 0) void'(sq_a[i].pop_front());
            if (rst_n && sq_a[i].size() > 0) begin
               v[i] = 1'b1;
               l[i] = sq_a[i][0][8];
               d[8*i +: 8] = sq_a[i][0][7:0];
            end
         end
         bus_a.in_req_valid = v;
         bus_a.in_req_last  = l;
         bus_a.in_req_data  = d;
         acc = v & bus_a.out_req_ready;
      end
   end

   // Requester 0 of arbiter B.
   initial begin
      logic acc;
      acc = 1'b0;
      bus_b.in_req_valid = 4'b0000;
      bus_b.in_req_last  = 4'b0000;
      bus_b.in_req_data  = 32'h0;
      forever begin
         @(negedge clk);
         if (rst_n && acc && sq_b.size() > 0) void'(sq_b.pop_front());
         bus_b.in_req_valid = {3'b000, rst_n && sq_b.size() > 0};
         bus_b.in_req_last  = (bus_b.in_req_valid[0]) ? {3'b000, sq_b[0][8]} : 4'b0000;
         bus_b.in_req_data  = (bus_b.in_req_valid[0]) ? {24'h0, sq_b[0][7:0]} : 32'h0;
         acc = bus_b.in_req_valid[0] & bus_b.out_req_ready[0];
      end
   end

   // FTDI ack model and monitors for arbiter A.
   initial begin
      int acnt;
      logic [3:0] prev_g;
      acnt = 0;
      prev_g = 4'b0000;
      bus_a.in_ctrl_tx_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_a.in_ctrl_tx_ack && bus_a.out_ctrl_tx_rdy) viol_cnt++;
         if (bus_a.out_timeout) to_cnt++;
         if (bus_a.out_busy && ((bus_a.out_req_ready & ~bus_a.in_req_valid) != 4'b0000)) stall_cnt++;
         if (bus_a.out_grant != 4'b0000 && bus_a.out_grant != prev_g) glog_a.push_back(bus_a.out_grant);
         prev_g = bus_a.out_grant;
         if (!rst_n) begin
            bus_a.in_ctrl_tx_ack = 1'b0; acnt = 0;
         end else if (!bus_a.in_ctrl_tx_ack) begin
            if (bus_a.out_ctrl_tx_rdy) begin
               if (acnt >= ack_lat) begin
                  bus_a.in_ctrl_tx_ack = 1'b1; log_a.push_back(bus_a.out_ctrl_data); acnt = 0;
               end else acnt++;
            end else acnt = 0;
         end else if (!bus_a.out_ctrl_tx_rdy) begin
            if (acnt >= ack_hold) begin
               bus_a.in_ctrl_tx_ack = 1'b0; acnt = 0;
            end else acnt++;
         end
      end
   end

   // FTDI ack model for arbiter B (fixed 2-cycle latency, no hold).
   initial begin
      int acnt;
      acnt = 0;
      bus_b.in_ctrl_tx_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bus_b.in_ctrl_tx_ack = 1'b0; acnt = 0;
         end else if (!bus_b.in_ctrl_tx_ack) begin
            if (bus_b.out_ctrl_tx_rdy) begin
               if (acnt >= 2) begin
                  bus_b.in_ctrl_tx_ack = 1'b1; log_b.push_back(bus_b.out_ctrl_data); acnt = 0;
               end else acnt++;
            end else acnt = 0;
         end else if (!bus_b.out_ctrl_tx_rdy) begin
            bus_b.in_ctrl_tx_ack = 1'b0;
         end
      end
   end

   task automatic wait_quiet(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         #1;
         if (sq_a[0].size() == 0 && sq_a[1].size() == 0 && sq_a[2].size() == 0 &&
             sq_a[3].size() == 0 && sq_b.size() == 0 && !bus_a.out_busy && !bus_b.out_busy &&
             !bus_a.in_ctrl_tx_ack && !bus_b.in_ctrl_tx_ack) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (bus_a.out_grant !== 4'b0000) begin n_errors++; $display("FAIL rst_grant: got %b expected 0000", bus_a.out_grant); end
      n_checks++; if (bus_a.out_busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b expected 0", bus_a.out_busy); end
      n_checks++; if (bus_a.out_ctrl_tx_rdy !== 1'b0) begin n_errors++; $display("FAIL rst_tx_rdy: got %b expected 0", bus_a.out_ctrl_tx_rdy); end
      n_checks++; if (bus_a.out_req_ready !== 4'b0000) begin n_errors++; $display("FAIL rst_ready: got %b expected 0000", bus_a.out_req_ready); end
      n_checks++; if (bus_a.out_ctrl_data !== 8'h00) begin n_errors++; $display("FAIL rst_data: got %h expected 00", bus_a.out_ctrl_data); end
      n_checks++; if (bus_a.out_timeout !== 1'b0) begin n_errors++; $display("FAIL rst_timeout: got %b expected 0", bus_a.out_timeout); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] exp [$];
      bit ok;
      exp = '{8'hA0, 8'h11, 8'h22};
      log_a.delete(); glog_a.delete();
      sq_a[0].push_back({1'b0, 8'h11});
      sq_a[0].push_back({1'b1, 8'h22});
      wait_quiet(400, ok);
      n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL basic_done: got %b expected 1", ok); end
      n_checks++;
      if (log_a.size() != exp.size()) begin n_errors++; $display("FAIL basic_len: got %0d expected %0d", log_a.size(), exp.size()); end
      else for (int k = 0; k < exp.size(); k++) begin
         n_checks++; if (log_a[k] !== exp[k]) begin n_errors++; $display("FAIL basic_byte%0d: got %h expected %h", k, log_a[k], exp[k]); end
      end
      n_checks++; if (glog_a.size() != 1 || glog_a[0] !== 4'b0001) begin n_errors++; $display("FAIL basic_grant: got %0d grants first %b expected 1 grant 0001", glog_a.size(), (glog_a.size() > 0) ? glog_a[0] : 4'b0000); end
      n_checks++; if (bus_a.out_grant !== 4'b0000) begin n_errors++; $display("FAIL basic_release: got %b expected 0000", bus_a.out_grant); end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp [$];
      logic [3:0] gexp [$];
      bit ok;
      exp  = '{8'hA1, 8'h31, 8'h32, 8'hA2, 8'h41, 8'hA3, 8'h60, 8'hA0, 8'h50};
      gexp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      log_a.delete(); glog_a.delete();
      sq_a[1].push_back({1'b0, 8'h31});
      sq_a[1].push_back({1'b1, 8'h32});
      sq_a[2].push_back({1'b1, 8'h41});
      wait_quiet(600, ok);
      n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL rr1_done: got %b expected 1", ok); end
      sq_a[0].push_back({1'b1, 8'h50});
      sq_a[3].push_back({1'b1, 8'h60});
      wait_quiet(600, ok);
      n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL rr2_done: got %b expected 1", ok); end
      n_checks++;
      if (log_a.size() != exp.size()) begin n_errors++; $display("FAIL rr_len: got %0d expected %0d", log_a.size(), exp.size()); end
      else for (int k = 0; k < exp.size(); k++) begin
         n_checks++; if (log_a[k] !== exp[k]) begin n_errors++; $display("FAIL rr_byte%0d: got %h expected %h", k, log_a[k], exp[k]); end
      end
      n_checks++;
      if (glog_a.size() != gexp.size()) begin n_errors++; $display("FAIL rr_grants: got %0d expected %0d", glog_a.size(), gexp.size()); end
      else for (int k = 0; k < gexp.size(); k++) begin
         n_checks++; if (glog_a[k] !== gexp[k]) begin n_errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, glog_a[k], gexp[k]); end
      end
   endtask

   task automatic test_timeout();
      logic [7:0] exp [$];
      bit ok;
      exp = '{8'hA3, 8'h70};
      log_a.delete(); to_cnt = 0; stall_cnt = 0;
      sq_a[3].push_back({1'b0, 8'h70});
      wait_quiet(600, ok);
      repeat (5) @(negedge clk);
      n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL tmo_done: got %b expected 1", ok); end
      n_checks++; if (to_cnt !== 1) begin n_errors++; $display("FAIL tmo_pulses: got %0d expected 1", to_cnt); end
      n_checks++; if (stall_cnt !== TMO + 1) begin n_errors++; $display("FAIL tmo_stall: got %0d expected %0d", stall_cnt, TMO + 1); end
      n_checks++;
      if (log_a.size() != exp.size()) begin n_errors++; $display("FAIL tmo_len: got %0d expected %0d", log_a.size(), exp.size()); end
      else for (int k = 0; k < exp.size(); k++) begin
         n_checks++; if (log_a[k] !== exp[k]) begin n_errors++; $display("FAIL tmo_byte%0d: got %h expected %h", k, log_a[k], exp[k]); end
      end
      n_checks++; if (bus_a.out_grant !== 4'b0000 || bus_a.out_busy !== 1'b0) begin n_errors++; $display("FAIL tmo_release: got grant %b busy %b expected 0000 0", bus_a.out_grant, bus_a.out_busy); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp [$];
      bit ok;
      bit seen;
      exp = '{8'hA2, 8'h90};
      seen = 1'b0;
      sq_a[1].push_back({1'b0, 8'h80});
      sq_a[1].push_back({1'b1, 8'h81});
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (bus_a.out_ctrl_tx_rdy) begin seen = 1'b1; break; end
      end
      n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL rmid_txrdy_seen: got %b expected 1", seen); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus_a.out_ctrl_tx_rdy !== 1'b0) begin n_errors++; $display("FAIL rmid_txrdy: got %b expected 0", bus_a.out_ctrl_tx_rdy); end
      n_checks++; if (bus_a.out_grant !== 4'b0000) begin n_errors++; $display("FAIL rmid_grant: got %b expected 0000", bus_a.out_grant); end
      n_checks++; if (bus_a.out_busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy: got %b expected 0", bus_a.out_busy); end
      for (int i = 0; i < 4; i++) sq_a[i].delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      log_a.delete();
      sq_a[2].push_back({1'b1, 8'h90});
      wait_quiet(400, ok);
      n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL rmid_done: got %b expected 1", ok); end
      n_checks++;
      if (log_a.size() != exp.size()) begin n_errors++; $display("FAIL rmid_len: got %0d expected %0d", log_a.size(), exp.size()); end
      else for (int k = 0; k < exp.size(); k++) begin
         n_checks++; if (log_a[k] !== exp[k]) begin n_errors++; $display("FAIL rmid_byte%0d: got %h expected %h", k, log_a[k], exp[k]); end
      end
   endtask

   task automatic test_no_header();
      bit ok;
      log_b.delete();
      sq_b.push_back({1'b1, 8'h55});
      wait_quiet(400, ok);
      n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL nohdr_done: got %b expected 1", ok); end
      n_checks++; if (log_b.size() !== 1) begin n_errors++; $display("FAIL nohdr_count: got %0d expected 1", log_b.size()); end
      n_checks++; if (log_b.size() > 0 && log_b[0] !== 8'h55) begin n_errors++; $display("FAIL nohdr_data: got %h expected 55", log_b[0]); end
   endtask

   task automatic test_ack_hold();
      logic [7:0] exp [$];
      bit ok;
      int n0;
      exp = '{8'hA0, 8'h01, 8'h02};
      log_a.delete(); viol_cnt = 0; ack_hold = 10;
      sq_a[0].push_back({1'b0, 8'h01});
      sq_a[0].push_back({1'b1, 8'h02});
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (log_a.size() > 0) break;
      end
      n0 = log_a.size();
      repeat (8) @(negedge clk);
      #1;
      n_checks++; if (bus_a.out_ctrl_tx_rdy !== 1'b0) begin n_errors++; $display("FAIL hold_txrdy: got %b expected 0", bus_a.out_ctrl_tx_rdy); end
      n_checks++; if (log_a.size() !== n0) begin n_errors++; $display("FAIL hold_nobyte: got %0d expected %0d", log_a.size(), n0); end
      wait_quiet(800, ok);
      ack_hold = 0;
      n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL hold_done: got %b expected 1", ok); end
      n_checks++; if (viol_cnt !== 0) begin n_errors++; $display("FAIL hold_interlock: got %0d expected 0", viol_cnt); end
      n_checks++;
      if (log_a.size() != exp.size()) begin n_errors++; $display("FAIL hold_len: got %0d expected %0d", log_a.size(), exp.size()); end
      else for (int k = 0; k < exp.size(); k++) begin
         n_checks++; if (log_a[k] !== exp[k]) begin n_errors++; $display("FAIL hold_byte%0d: got %h expected %h", k, log_a[k], exp[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_timeout();
      test_reset_mid();
      test_no_header();
      test_ack_hold();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
